riscv_ex_fwd_stage: RTL and testbench

- Parametrised successor to the single-lane EX5 result register; the stage between the last ALU stage and writeback.
- Carries LANES results per bundle through a 2-entry skid buffer with valid/ready backpressure and pipeline flush.
- Exposes NRP combinational bypass lookup ports that return the youngest matching in-flight result to the operand-forwarding network.

---
 rtl/riscv_ex_fwd_stage.sv | 152 +++++++++++++++
 tb/tb_riscv_ex_fwd_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_fwd_stage.sv
// EX->WB result stage: 2-entry skid buffer carrying LANES results per bundle,
// with NRP combinational bypass lookup ports (youngest match wins).
module riscv_ex_fwd_stage #(
  parameter int XLEN  = 32,
  parameter int LANES = 2,
  parameter int RA_W  = 5,
  parameter int NRP   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_vld,
  input  logic [LANES-1:0]        in_rd_we,
  input  logic [LANES*RA_W-1:0]   in_rd,
  input  logic [LANES*XLEN-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [LANES-1:0]        out_rd_we,
  output logic [LANES*RA_W-1:0]   out_rd,
  output logic [LANES*XLEN-1:0]   out_data,
  output logic [1:0]              occ,
  input  logic [NRP*RA_W-1:0]     byp_rs,
  output logic [NRP-1:0]          byp_hit,
  output logic [NRP*XLEN-1:0]     byp_data
);

  logic                  r_main_full;
  logic                  r_skid_full;
  logic                  r_in_ready;
  logic [LANES-1:0]      r_main_vld;
  logic [LANES-1:0]      r_main_we;
  logic [LANES*RA_W-1:0] r_main_rd;
  logic [LANES*XLEN-1:0] r_main_data;
  logic [LANES-1:0]      r_skid_vld;
  logic [LANES-1:0]      r_skid_we;
  logic [LANES*RA_W-1:0] r_skid_rd;
  logic [LANES*XLEN-1:0] r_skid_data;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_from_skid;
  logic w_load_main;
  logic w_load_skid;
  logic w_main_nxt;
  logic w_skid_nxt;

  logic [NRP-1:0]      w_hit;
  logic [NRP*XLEN-1:0] w_bdata;
  logic [RA_W-1:0]     w_rs;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_main_full & out_ready;

  // skid can only be full when in_ready is low, so it never races an input
  assign w_main_from_skid = w_out_fire & r_skid_full;
  assign w_load_main = w_in_fire &
    (~r_main_full | (w_out_fire & ~r_skid_full));
  assign w_load_skid = w_in_fire & ~w_load_main;

  assign w_main_nxt = w_load_main | w_main_from_skid |
                      (r_main_full & ~w_out_fire);
  assign w_skid_nxt = w_load_skid | (r_skid_full & ~w_out_fire);

  // occupancy and registered ready; flush empties both entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_full <= 1'b0;
      r_skid_full <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_main_full <= 1'b0;
      r_skid_full <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_main_full <= w_main_nxt;
      r_skid_full <= w_skid_nxt;
      r_in_ready  <= ~w_skid_nxt;
    end
  end

  // payload storage, unreset; contents only meaningful while full
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (w_load_main) begin
        r_main_vld  <= in_lane_vld;
        r_main_we   <= in_rd_we;
        r_main_rd   <= in_rd;
        r_main_data <= in_data;
      end else if (w_main_from_skid) begin
        r_main_vld  <= r_skid_vld;
        r_main_we   <= r_skid_we;
        r_main_rd   <= r_skid_rd;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_vld  <= in_lane_vld;
        r_skid_we   <= in_rd_we;
        r_skid_rd   <= in_rd;
        r_skid_data <= in_data;
      end
    end
  end

  // bypass: later assignments override, so scan oldest to youngest
  always_comb begin
    w_hit   = '0;
    w_bdata = '0;
    w_rs    = '0;
    for (int p = 0; p < NRP; p++) begin
      w_rs = byp_rs[p*RA_W +: RA_W];
      for (int l = 0; l < LANES; l++) begin
        if (r_main_full && r_main_vld[l] && r_main_we[l] &&
            r_main_rd[l*RA_W +: RA_W] == w_rs) begin
          w_hit[p] = 1'b1;
          w_bdata[p*XLEN +: XLEN] = r_main_data[l*XLEN +: XLEN];
        end
      end
      for (int l = 0; l < LANES; l++) begin
        if (r_skid_full && r_skid_vld[l] && r_skid_we[l] &&
            r_skid_rd[l*RA_W +: RA_W] == w_rs) begin
          w_hit[p] = 1'b1;
          w_bdata[p*XLEN +: XLEN] = r_skid_data[l*XLEN +: XLEN];
        end
      end
      if (w_rs == '0 || flush) begin
        w_hit[p] = 1'b0;
        w_bdata[p*XLEN +: XLEN] = '0;
      end
    end
  end

  assign byp_hit      = w_hit;
  assign byp_data     = w_bdata;
  assign in_ready     = r_in_ready;
  assign out_valid    = r_main_full;
  assign out_lane_vld = r_main_vld;
  assign out_rd_we    = r_main_we;
  assign out_rd       = r_main_rd;
  assign out_data     = r_main_data;
  assign occ = {1'b0, r_main_full} + {1'b0, r_skid_full};

  a_skid_main: assert property (@(posedge clk) disable iff (!rst_n)
    r_skid_full |-> r_main_full);
  a_occ: assert property (@(posedge clk) disable iff (!rst_n)
    occ != 2'd3);
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r_main_full && !out_ready && !flush) |=> $stable(r_main_data));

endmodule

// File: tb/tb_riscv_ex_fwd_stage.sv
// Directed + random bench for riscv_ex_fwd_stage against a queue-based
// model of the in-flight bundles.
module tb_riscv_ex_fwd_stage;
  localparam int XLEN = 32;
  localparam int LANES = 2;
  localparam int RA_W = 5;
  localparam int NRP = 4;

  typedef struct packed {
    logic [1:0]       vld;
    logic [1:0]       we;
    logic [1:0][4:0]  rd;
    logic [1:0][31:0] data;
  } bund_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  bund_t cur = '0;
  logic [3:0][4:0] rs_a = '0;

  logic in_ready, out_valid;
  logic [1:0] out_lane_vld, out_rd_we, occ;
  logic [9:0] out_rd;
  logic [63:0] out_data;
  logic [3:0] byp_hit;
  logic [127:0] byp_data;

  bund_t q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_ex_fwd_stage #(
    .XLEN(XLEN), .LANES(LANES), .RA_W(RA_W), .NRP(NRP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(cur.vld), .in_rd_we(cur.we),
    .in_rd(cur.rd), .in_data(cur.data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_vld(out_lane_vld), .out_rd_we(out_rd_we),
    .out_rd(out_rd), .out_data(out_data), .occ(occ),
    .byp_rs(rs_a), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // youngest bundle first, highest lane first
  task automatic ref_byp(input logic [4:0] rs,
                         output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (rs != 0 && !flush)
      for (int e = q.size() - 1; e >= 0; e--)
        for (int l = LANES - 1; l >= 0; l--)
          if (!h && q[e].vld[l] && q[e].we[l] && q[e].rd[l] == rs) begin
            h = 1'b1;
            d = q[e].data[l];
          end
  endtask

  task automatic check_all(string t);
    logic h;
    logic [31:0] d;
    chk({t, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({t, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    chk({t, ".occ"}, 64'(occ), 64'(q.size()));
    if (q.size() > 0) begin
      chk({t, ".vld"}, 64'(out_lane_vld), 64'(q[0].vld));
      chk({t, ".we"}, 64'(out_rd_we), 64'(q[0].we));
      chk({t, ".rd"}, 64'(out_rd), 64'(q[0].rd));
      chk({t, ".data"}, out_data, 64'(q[0].data));
    end
    for (int p = 0; p < NRP; p++) begin
      ref_byp(rs_a[p], h, d);
      chk($sformatf("%s.hit%0d", t, p), 64'(byp_hit[p]), 64'(h));
      chk($sformatf("%s.bdat%0d", t, p),
          64'(byp_data[p*32 +: 32]), 64'(d));
    end
  endtask

  task automatic tick();
    logic fin, fout;
    fin  = in_valid && (q.size() < 2);
    fout = out_ready && (q.size() > 0);
    @(posedge clk);
    if (rst_n) begin
      if (flush) q.delete();
      else begin
        if (fout) void'(q.pop_front());
        if (fin) q.push_back(cur);
      end
    end
    @(negedge clk);
  endtask

  task automatic async_reset(string t);
    rst_n = 1'b0;
    #1;
    q.delete();
    check_all(t);
    chk({t, ".hit_any"}, 64'(byp_hit), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bund_t mk(logic [1:0] v, logic [1:0] w,
                               logic [4:0] r0, logic [31:0] d0,
                               logic [4:0] r1, logic [31:0] d1);
    bund_t b;
    b.vld = v;
    b.we = w;
    b.rd[0] = r0;
    b.data[0] = d0;
    b.rd[1] = r1;
    b.data[1] = d1;
    return b;
  endfunction

  function automatic bund_t rnd();
    bund_t b;
    b.vld = 2'($urandom);
    b.we = 2'($urandom);
    b.rd[0] = 5'($urandom_range(0, 7));
    b.rd[1] = 5'($urandom_range(0, 7));
    b.data[0] = $urandom;
    b.data[1] = $urandom;
    return b;
  endfunction

  initial begin
    // reset with in_valid already high
    in_valid = 1'b1;
    cur = mk(2'b11, 2'b11, 5'd5, 32'h11, 5'd6, 32'h22);
    rs_a = {5'd6, 5'd5, 5'd0, 5'd3};
    #1 rst_n = 1'b0;
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_all("post_reset");
    tick();
    check_all("first_A");
    chk("A.data", out_data, 64'h00000022_00000011);

    // backpressure: B lands in skid, C must not enter
    cur = mk(2'b11, 2'b11, 5'd1, 32'h33, 5'd2, 32'h44);
    tick();
    check_all("AB_full");
    chk("AB.occ", 64'(occ), 64'd2);
    chk("AB.in_ready", 64'(in_ready), 64'd0);
    cur = mk(2'b11, 2'b11, 5'd3, 32'h55, 5'd4, 32'h66);
    tick();
    check_all("C_blocked");
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_all("A_left");
    chk("B.data", out_data, 64'h00000044_00000033);
    tick();
    check_all("B_left");

    // streaming 100 random bundles
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cur = rnd();
      for (int p = 0; p < NRP; p++) rs_a[p] = 5'($urandom_range(0, 7));
      tick();
      check_all("stream");
    end
    in_valid = 1'b0;
    tick();
    check_all("stream_drain");

    // bypass priority: skid lane0 younger than main lane1
    out_ready = 1'b0;
    in_valid = 1'b1;
    cur = mk(2'b11, 2'b11, 5'd0, 32'h77, 5'd7, 32'hAA);
    tick();
    cur = mk(2'b11, 2'b11, 5'd7, 32'hBB, 5'd8, 32'hCC);
    tick();
    in_valid = 1'b0;
    rs_a = {5'd8, 5'd0, 5'd3, 5'd7};
    #1;
    check_all("byp_skid");
    chk("byp_skid.d", 64'(byp_data[31:0]), 64'hBB);
    chk("byp_rs0", 64'(byp_hit[2]), 64'd0);

    // flush with occ=2 and in_valid high
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    check_all("flush_cyc");
    chk("flush.hit", 64'(byp_hit), 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_all("post_flush");
    chk("post_flush.occ", 64'(occ), 64'd0);

    // same setup, skid lane0 killed
    in_valid = 1'b1;
    cur = mk(2'b11, 2'b11, 5'd0, 32'h77, 5'd7, 32'hAA);
    tick();
    cur = mk(2'b10, 2'b11, 5'd7, 32'hBB, 5'd8, 32'hCC);
    tick();
    in_valid = 1'b0;
    check_all("byp_main");
    chk("byp_main.d", 64'(byp_data[31:0]), 64'hAA);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // intra-bundle priority
    in_valid = 1'b1;
    cur = mk(2'b11, 2'b11, 5'd9, 32'h1, 5'd9, 32'h2);
    rs_a = {5'd9, 5'd9, 5'd9, 5'd9};
    tick();
    in_valid = 1'b0;
    check_all("lane_prio");
    chk("lane_prio.d", 64'(byp_data[63:32]), 64'h2);
    out_ready = 1'b1;
    in_valid = 1'b1;
    cur = mk(2'b11, 2'b01, 5'd9, 32'h1, 5'd9, 32'h2);
    tick();
    in_valid = 1'b0;
    check_all("lane_we");
    chk("lane_we.d", 64'(byp_data[95:64]), 64'h1);

    // random mix with flush and a mid-stream async reset
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      cur = rnd();
      for (int p = 0; p < NRP; p++) rs_a[p] = 5'($urandom_range(0, 7));
      #1;
      check_all("mix_pre");
      tick();
      if (i == 150) async_reset("async_rst");
    end
    flush = 1'b0;
    in_valid = 1'b0;
    check_all("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
